// File: rtl/mult_pipe_pkg.sv
// Shared helpers for the parametrised pipelined multiplier.
// Operand extension is written against a maximum width so one function serves every WIDTH.
package mult_pipe_pkg;

    localparam int MAX_W = 64;

    // Widen an operand by one bit: sign bit copied in signed mode, zero otherwise.
    // The result is only meaningful in bits [w:0].
    function automatic logic [MAX_W:0] ext_op(input logic [MAX_W-1:0] op,
                                              input logic [6:0]       w,
                                              input logic             signed_mode);
        logic [MAX_W:0] r;
        r    = {1'b0, op};
        r[w] = signed_mode & r[w - 7'd1];
        return r;
    endfunction

endpackage

// File: rtl/mult_pipe_slice.sv
// One enable-gated pipeline register slice: valid bit plus a PW-bit payload.
module mult_pipe_slice #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          d_valid,
    input  logic [PW-1:0] d_data,
    output logic          q_valid,
    output logic [PW-1:0] q_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/mult_pipe_param.sv
// Parametrised pipelined WIDTHxWIDTH multiplier with valid/ready handshakes and per-beat signed mode.
// Optional accumulator on the output stream when MULT_PIPE_ACCUM_EN is defined.
module mult_pipe_param
    import mult_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P
`ifdef MULT_PIPE_ACCUM_EN
   ,input  logic               acc_clr,
    output logic [2*WIDTH+3:0] ACC
`endif
);

    localparam int HALF = WIDTH / 2;
    localparam int OW   = WIDTH + 1;       // extended operand
    localparam int PPW  = 2 * HALF + 2;    // one signed partial product
`ifdef MULT_PIPE_ACCUM_EN
    localparam int MB   = 1;               // mode bit rides along for the accumulator
`else
    localparam int MB   = 0;
`endif
    localparam int S0W  = 2 * OW + MB;
    localparam int PPBW = 4 * PPW + MB;
    localparam int FW   = 2 * WIDTH + MB;
    localparam int LAST = STAGES - 2;

    if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > MAX_W || STAGES < 2) begin : g_bad_param
        $error("mult_pipe_param: WIDTH must be even in [4,%0d] and STAGES >= 2", MAX_W);
    end

    // Operands split as signed hi (HALF+1 bits) and unsigned lo (HALF bits).
    function automatic logic [4*PPW-1:0] pp_of(input logic [2*OW-1:0] ops);
        logic signed [HALF:0]  a_hi, a_lo, b_hi, b_lo;
        logic signed [PPW-1:0] hh, hl, lh, ll;
        a_hi = ops[2*OW-1 -: HALF+1];
        a_lo = {1'b0, ops[OW +: HALF]};
        b_hi = ops[OW-1 -: HALF+1];
        b_lo = {1'b0, ops[0 +: HALF]};
        hh   = PPW'(a_hi) * PPW'(b_hi);
        hl   = PPW'(a_hi) * PPW'(b_lo);
        lh   = PPW'(a_lo) * PPW'(b_hi);
        ll   = PPW'(a_lo) * PPW'(b_lo);
        return {hh, hl, lh, ll};
    endfunction

    // The exact product always fits in 2*WIDTH bits, so modular summation is exact.
    function automatic logic [2*WIDTH-1:0] sum_of(input logic [4*PPW-1:0] pp);
        logic [2*WIDTH-1:0] hh, hl, lh, ll;
        hh = {{(2*WIDTH-PPW){pp[4*PPW-1]}}, pp[4*PPW-1 -: PPW]};
        hl = {{(2*WIDTH-PPW){pp[3*PPW-1]}}, pp[3*PPW-1 -: PPW]};
        lh = {{(2*WIDTH-PPW){pp[2*PPW-1]}}, pp[2*PPW-1 -: PPW]};
        ll = {{(2*WIDTH-PPW){pp[PPW-1]}},   pp[PPW-1 -: PPW]};
        return (hh << (2*HALF)) + (hl << HALF) + (lh << HALF) + ll;
    endfunction

    logic                        adv;
    logic [OW-1:0]               ea, eb;
    logic [S0W-1:0]              s0_d, s0_q;
    logic                        s0_v;
    logic [LAST:0]               cv;
    logic [LAST:0][PPBW-1:0]     cd;
    logic [FW-1:0]               fin_d, fin_q;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    assign ea = OW'(ext_op(MAX_W'(A), 7'(WIDTH), signed_mode));
    assign eb = OW'(ext_op(MAX_W'(B), 7'(WIDTH), signed_mode));

`ifdef MULT_PIPE_ACCUM_EN
    assign s0_d  = {signed_mode, ea, eb};
    assign cd[0] = {s0_q[S0W-1], pp_of(s0_q[2*OW-1:0])};
    assign fin_d = {cd[LAST][PPBW-1], sum_of(cd[LAST][4*PPW-1:0])};
`else
    assign s0_d  = {ea, eb};
    assign cd[0] = pp_of(s0_q);
    assign fin_d = sum_of(cd[LAST]);
`endif

    mult_pipe_slice #(.PW(S0W)) u_s0 (
        .clk(clk), .rst_n(rst_n), .en(adv),
        .d_valid(in_valid), .d_data(s0_d),
        .q_valid(s0_v), .q_data(s0_q)
    );

    // Entry 0 is the combinational partial products; entries 1..LAST are registered
    // (the pp register plus any pure delay slices). With STAGES=2 there are none.
    assign cv[0] = s0_v;
    for (genvar i = 1; i <= LAST; i++) begin : g_mid
        mult_pipe_slice #(.PW(PPBW)) u_mid (
            .clk(clk), .rst_n(rst_n), .en(adv),
            .d_valid(cv[i-1]), .d_data(cd[i-1]),
            .q_valid(cv[i]), .q_data(cd[i])
        );
    end

    mult_pipe_slice #(.PW(FW)) u_fin (
        .clk(clk), .rst_n(rst_n), .en(adv),
        .d_valid(cv[LAST]), .d_data(fin_d),
        .q_valid(out_valid), .q_data(fin_q)
    );

`ifdef MULT_PIPE_ACCUM_EN
    localparam int AW = 2 * WIDTH + 4;
    logic          fin_mode;
    logic          hs;
    logic [AW-1:0] p_ext;

    assign {fin_mode, P} = fin_q;
    assign hs    = out_valid & out_ready;
    assign p_ext = {{4{fin_mode & P[2*WIDTH-1]}}, P};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ACC <= '0;
        else if (hs)      ACC <= (acc_clr ? '0 : ACC) + p_ext;
        else if (acc_clr) ACC <= '0;
    end
`else
    assign P = fin_q;
`endif

endmodule

// File: tb/tb_mult_pipe_param.sv
// Directed, table-driven bench for mult_pipe_param (8x8/3-stage and 16x16/5-stage instances).
module tb_mult_pipe_param;

    localparam int W  = 8;
    localparam int S  = 3;
    localparam int WW = 16;
    localparam int WS = 5;
    localparam int N  = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           in_valid, in_ready, signed_mode, out_valid, out_ready;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] p;

    logic            w_in_valid, w_in_ready, w_sm, w_out_valid, w_out_ready;
    logic [WW-1:0]   wa, wb;
    logic [2*WW-1:0] wp;

`ifdef MULT_PIPE_ACCUM_EN
    logic            acc_clr, w_acc_clr;
    logic [2*W+3:0]  acc;
    logic [2*WW+3:0] w_acc;
`endif

    mult_pipe_param #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready), .P(p)
`ifdef MULT_PIPE_ACCUM_EN
       ,.acc_clr(acc_clr), .ACC(acc)
`endif
    );

    mult_pipe_param #(.WIDTH(WW), .STAGES(WS)) u_wide (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .A(wa), .B(wb), .signed_mode(w_sm),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .P(wp)
`ifdef MULT_PIPE_ACCUM_EN
       ,.acc_clr(w_acc_clr), .ACC(w_acc)
`endif
    );

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sm;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vt[N];
    vec_t bp[6];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        a           = v.a;
        b           = v.b;
        signed_mode = v.sm;
        in_valid    = 1'b1;
    endtask

    initial begin
        vt[0]  = '{8'd3,   8'd2,   1'b0, 16'd6};
        vt[1]  = '{8'd7,   8'd4,   1'b0, 16'd28};
        vt[2]  = '{8'd255, 8'd255, 1'b0, 16'd65025};
        vt[3]  = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
        vt[4]  = '{8'h80,  8'h7F,  1'b1, 16'hC080};
        vt[5]  = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
        vt[6]  = '{8'h05,  8'hFD,  1'b1, 16'hFFF1};
        vt[7]  = '{8'd0,   8'd200, 1'b0, 16'h0000};
        vt[8]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vt[9]  = '{8'h7F,  8'h7F,  1'b1, 16'h3F01};
        vt[10] = '{8'h80,  8'h02,  1'b0, 16'h0100};
        vt[11] = '{8'h80,  8'h02,  1'b1, 16'hFF00};

        bp[0] = '{8'd2,  8'd3,  1'b0, 16'd6};
        bp[1] = '{8'd4,  8'd5,  1'b0, 16'd20};
        bp[2] = '{8'd6,  8'd7,  1'b0, 16'd42};
        bp[3] = '{8'd8,  8'd9,  1'b0, 16'd72};
        bp[4] = '{8'd10, 8'd11, 1'b0, 16'd110};
        bp[5] = '{8'd12, 8'd13, 1'b0, 16'd156};

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; wa = '0; wb = '0; w_sm = 1'b0; w_out_ready = 1'b1;
`ifdef MULT_PIPE_ACCUM_EN
        acc_clr = 1'b0; w_acc_clr = 1'b0;
`endif
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_p", 64'(p), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wide_valid", 64'(w_out_valid), 64'd0);
        check("rst_wide_p", 64'(wp), 64'd0);
`ifdef MULT_PIPE_ACCUM_EN
        check("rst_acc", 64'(acc), 64'd0);
`endif
        tick(); tick();
        rst_n = 1'b1;

        // Back-to-back stream: beat accepted at edge e shows up after edge e+S-1.
        drive(vt[0]);
        for (int e = 0; e < N + S; e++) begin
            tick();
            if (e >= S - 1 && e - (S - 1) < N) begin
                check($sformatf("vec%0d_valid", e - S + 1), 64'(out_valid), 64'd1);
                check($sformatf("vec%0d_p", e - S + 1), 64'(p), 64'(vt[e - S + 1].p));
            end else begin
                check($sformatf("stream_idle_e%0d", e), 64'(out_valid), 64'd0);
            end
            check("stream_in_ready", 64'(in_ready), 64'd1);
            if (e + 1 < N) drive(vt[e + 1]);
            else           in_valid = 1'b0;
        end

        // Backpressure: fill with out_ready low, hold, then drain in order.
        out_ready = 1'b0;
        drive(bp[0]); tick();
        drive(bp[1]); tick();
        drive(bp[2]); tick();
        check("bp_full_valid", 64'(out_valid), 64'd1);
        check("bp_full_p", 64'(p), 64'(bp[0].p));
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        drive(bp[3]);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("bp_hold%0d_in_ready", i), 64'(in_ready), 64'd0);
            check($sformatf("bp_hold%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("bp_hold%0d_p", i), 64'(p), 64'(bp[0].p));
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("bp_drain%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("bp_drain%0d_p", i), 64'(p), 64'(bp[i].p));
            if (i + 3 <= 5) drive(bp[i + 3]);
            else            in_valid = 1'b0;
        end
        tick();
        check("bp_drain_empty", 64'(out_valid), 64'd0);

        // Bubble pattern 1,0,1.
        a = 8'd9; b = 8'd9; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'd50; b = 8'd50; in_valid = 1'b0;
        tick();
        a = 8'd10; b = 8'd10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bub0_valid", 64'(out_valid), 64'd1);
        check("bub0_p", 64'(p), 64'd81);
        tick();
        check("bub1_valid", 64'(out_valid), 64'd0);
        tick();
        check("bub2_valid", 64'(out_valid), 64'd1);
        check("bub2_p", 64'(p), 64'd100);
        tick();
        check("bub3_valid", 64'(out_valid), 64'd0);

        // Reset with three beats in flight.
        a = 8'd1; b = 8'd1; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'd2; b = 8'd2;
        tick();
        a = 8'd3; b = 8'd3;
        tick();
        in_valid = 1'b0;
        check("rstmid_pre_valid", 64'(out_valid), 64'd1);
        check("rstmid_pre_p", 64'(p), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", 64'(out_valid), 64'd0);
        check("rstmid_p", 64'(p), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rstmid_after%0d_valid", i), 64'(out_valid), 64'd0);
        end

        // Wide instance, five stages.
        wa = 16'hFFFF; wb = 16'hFFFF; w_sm = 1'b0; w_in_valid = 1'b1;
        tick();
        wa = 16'h8000; wb = 16'h8000; w_sm = 1'b1;
        tick();
        wa = 16'hFED4; wb = 16'h0007; w_sm = 1'b1;
        tick();
        w_in_valid = 1'b0;
        tick();
        check("wide_early_valid", 64'(w_out_valid), 64'd0);
        tick();
        check("wide0_valid", 64'(w_out_valid), 64'd1);
        check("wide0_p", 64'(wp), 64'hFFFE0001);
        tick();
        check("wide1_p", 64'(wp), 64'h40000000);
        tick();
        check("wide2_p", 64'(wp), 64'hFFFFF7CC);
        tick();
        check("wide_empty", 64'(w_out_valid), 64'd0);

`ifdef MULT_PIPE_ACCUM_EN
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("acc_clr_idle", 64'(acc), 64'd0);
        a = 8'd3; b = 8'd2; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'd7; b = 8'd4;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("acc_first", 64'(acc), 64'd6);
        tick();
        check("acc_sum", 64'(acc), 64'd34);
        a = 8'hFF; b = 8'h01; signed_mode = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("acc_signed", 64'(acc), 64'd33);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("acc_clr_final", 64'(acc), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
